// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor with a valid/ready handshake.
// Each register stage resolves one STAGE_BITS lookahead slice. The slice carry
// is registered between stages. Operands are shifted right by one slice per
// stage, so the active slice always sits at bits [STAGE_BITS-1:0]. Finished
// sum bits are shifted in from the top.
// Optional feature: define ADDSUB_SAT_EN to clamp S on signed overflow.
module pipelined_cla_addsub #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned STAGE_BITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             m,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             CF,
  output logic             OF
);

  localparam int unsigned SB     = STAGE_BITS;
  localparam int unsigned STAGES = WIDTH / STAGE_BITS;
  localparam int unsigned LAST   = STAGES - 1;

  // One lookahead slice; returns {carry into slice MSB, carry out, sum bits}
  function automatic logic [SB+1:0] cla_slice(input logic [SB-1:0] a,
                                               input logic [SB-1:0] b,
                                               input logic          ci);
    logic [SB-1:0] g;
    logic [SB-1:0] p;
    logic [SB:0]   c;
    logic          pp;
    g    = a & b;
    p    = a | b;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < int'(SB); i++) begin
      c[i+1] = g[i];
      pp     = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (pp & g[j]);
        pp     = pp & p[j];
      end
      c[i+1] = c[i+1] | (pp & ci);
    end
    return {c[SB-1], c[SB], a ^ b ^ c[SB-1:0]};
  endfunction

  logic             vld_q [STAGES];
  logic             vld_d [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] a_d   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] b_d   [STAGES];
  logic [WIDTH-1:0] s_q   [STAGES];
  logic [WIDTH-1:0] s_d   [STAGES];
  logic             c_q   [STAGES];
  logic             c_d   [STAGES];
  logic             m_q   [STAGES];
  logic             m_d   [STAGES];
  logic             cf_q;
  logic             cf_d;
  logic             of_q;
  logic             of_d;

  logic             src_v [STAGES];
  logic [WIDTH-1:0] src_a [STAGES];
  logic [WIDTH-1:0] src_b [STAGES];
  logic [WIDTH-1:0] src_s [STAGES];
  logic             src_c [STAGES];
  logic             src_m [STAGES];
  logic [SB+1:0]    slice_r [STAGES];
  logic             en;

  // Global advance: the whole pipe moves unless a result is stuck at the output
  always_comb begin
    en = !vld_q[LAST] || out_ready;
  end

  assign in_ready  = en;
  assign out_valid = vld_q[LAST];
  assign S         = s_q[LAST];
  assign CF        = cf_q;
  assign OF        = of_q;

  // Inputs feeding each slice: stage 0 from the ports, later stages from the previous register
  always_comb begin
    src_v[0] = in_valid;
    src_a[0] = A;
    src_b[0] = B ^ {WIDTH{m}};
    src_s[0] = '0;
    src_c[0] = Cin ^ m;
    src_m[0] = m;
    for (int k = 1; k < int'(STAGES); k++) begin
      src_v[k] = vld_q[k-1];
      src_a[k] = a_q[k-1];
      src_b[k] = b_q[k-1];
      src_s[k] = s_q[k-1];
      src_c[k] = c_q[k-1];
      src_m[k] = m_q[k-1];
    end
  end

  // Lookahead result of the active slice in every stage
  always_comb begin
    for (int k = 0; k < int'(STAGES); k++) begin
      slice_r[k] = cla_slice(src_a[k][SB-1:0], src_b[k][SB-1:0], src_c[k]);
    end
  end

  // Next-state: hold everything on stall, otherwise shift each op one slice forward
  always_comb begin
    for (int k = 0; k < int'(STAGES); k++) begin
      vld_d[k] = vld_q[k];
      a_d[k]   = a_q[k];
      b_d[k]   = b_q[k];
      s_d[k]   = s_q[k];
      c_d[k]   = c_q[k];
      m_d[k]   = m_q[k];
    end
    cf_d = cf_q;
    of_d = of_q;
    if (en) begin
      for (int k = 0; k < int'(STAGES); k++) begin
        vld_d[k] = src_v[k];
        a_d[k]   = src_a[k] >> SB;
        b_d[k]   = src_b[k] >> SB;
        s_d[k]   = (src_s[k] >> SB) | (WIDTH'(slice_r[k][SB-1:0]) << (WIDTH - SB));
        c_d[k]   = slice_r[k][SB];
        m_d[k]   = src_m[k];
      end
      cf_d = slice_r[LAST][SB] ^ src_m[LAST];
      of_d = slice_r[LAST][SB+1] ^ slice_r[LAST][SB];
`ifdef ADDSUB_SAT_EN
      // Clamp toward the sign of A (the active slice MSB in the last stage is A's MSB)
      if (of_d) begin
        s_d[LAST] = src_a[LAST][SB-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                      : {1'b0, {(WIDTH-1){1'b1}}};
      end
`endif
    end
  end

  // Stage registers with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < int'(STAGES); k++) begin
        vld_q[k] <= 1'b0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        s_q[k]   <= '0;
        c_q[k]   <= 1'b0;
        m_q[k]   <= 1'b0;
      end
      cf_q <= 1'b0;
      of_q <= 1'b0;
    end else begin
      for (int k = 0; k < int'(STAGES); k++) begin
        vld_q[k] <= vld_d[k];
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        s_q[k]   <= s_d[k];
        c_q[k]   <= c_d[k];
        m_q[k]   <= m_d[k];
      end
      cf_q <= cf_d;
      of_q <= of_d;
    end
  end

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Bench for pipelined_cla_addsub (WIDTH=16, STAGE_BITS=4): directed literals,
// stall/hold behaviour, asynchronous reset flush and randomized traffic
// against an integer-arithmetic reference model.
`timescale 1ns/1ps
module tb_pipelined_cla_addsub;

  localparam int unsigned W   = 16;
  localparam int          LAT = 4;
  localparam longint      M   = 64'sd65536;
  localparam longint      HI  = 64'sd32767;
  localparam longint      LO  = -64'sd32768;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic         m;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] S;
  logic         CF;
  logic         OF;

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [W+1:0] exp_q[$];
  logic         rand_or = 1'b0;
  logic         hold_prev = 1'b0;
  logic [W+1:0] hold_val = '0;

  pipelined_cla_addsub #(.WIDTH(16), .STAGE_BITS(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Cin(Cin), .m(m),
    .out_valid(out_valid), .out_ready(out_ready),
    .S(S), .CF(CF), .OF(OF)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic, returns {S, CF, OF}
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic md);
    longint ua, ub, sa, sb, ur, sr, ci;
    logic [W-1:0] s;
    logic cf, of;
    ua = longint'(a);
    ub = longint'(b);
    ci = cin ? 64'sd1 : 64'sd0;
    sa = a[W-1] ? ua - M : ua;
    sb = b[W-1] ? ub - M : ub;
    if (!md) begin
      ur = ua + ub + ci;
      sr = sa + sb + ci;
      cf = (ur >= M);
    end else begin
      ur = ua - ub - ci;
      sr = sa - sb - ci;
      cf = (ur < 0);
    end
    s  = ur[W-1:0];
    of = (sr > HI) || (sr < LO);
`ifdef ADDSUB_SAT_EN
    if (of) s = a[W-1] ? 16'h8000 : 16'h7FFF;
`endif
    return {s, cf, of};
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h7FFF;
      3: return 16'h8000;
      4: return 16'h0001;
      default: return W'($urandom);
    endcase
  endfunction

  // Scoreboard and handshake/hold checks, sampled mid-cycle
  always @(negedge clk) begin
    logic [W+1:0] e;
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      chk("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
      if (hold_prev) chk("output_hold", 32'({out_valid, S, CF, OF}), 32'({1'b1, hold_val}));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_output: got S=%h CF=%b OF=%b required no result", S, CF, OF);
        end else begin
          e = exp_q.pop_front();
          chk("result", 32'({S, CF, OF}), 32'(e));
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(A, B, Cin, m));
      hold_prev = out_valid && !out_ready;
      hold_val  = {S, CF, OF};
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic md);
    int   guard;
    logic acc;
    A = a; B = b; Cin = cin; m = md; in_valid = 1'b1;
    guard = 0;
    acc   = 1'b0;
    while (!acc && guard < 100) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!acc) chk("send_timeout", 32'(acc), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      @(posedge clk);
      g++;
    end
    chk(nm, 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic directed(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic md, input logic [W-1:0] s_raw,
                          input logic [W-1:0] s_sat, input logic cf, input logic of);
    logic [W+1:0] e;
    int lat;
`ifdef ADDSUB_SAT_EN
    e = {s_sat, cf, of};
`else
    e = {s_raw, cf, of};
`endif
    chk({nm, "_model"}, 32'(model(a, b, cin, md)), 32'(e));
    send(a, b, cin, md);
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, "_latency"}, 32'(lat), 32'(LAT));
    chk({nm, "_dut"}, 32'({S, CF, OF}), 32'(e));
    drain({nm, "_drain"});
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; Cin = 1'b0; m = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_S", 32'(S), 32'd0);
    chk("reset_flags", 32'({CF, OF}), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    directed("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 16'h7FFF, 1'b0, 1'b1);
    directed("sub_borrow", 16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    directed("sub_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 16'h8000, 1'b0, 1'b1);
    directed("ripple",     16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
    directed("borrow_in",  16'h1234, 16'h1234, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    directed("carry_in",   16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 16'h7FFF, 1'b0, 1'b1);
    directed("plain_add",  16'h1234, 16'h0FED, 1'b0, 1'b0, 16'h2221, 16'h2221, 1'b0, 1'b0);

    // 8 back-to-back ops with a 3-cycle output stall
    fork
      begin
        for (int i = 0; i < 8; i++) send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain("stall_drain");

    // Asynchronous reset with ops in flight and a result at the output
    for (int i = 0; i < 4; i++) send(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    #1 rst = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_S", 32'(S), 32'd0);
    chk("rst_flags", 32'({CF, OF}), 32'd0);
    exp_q.delete();
    @(negedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    repeat (10) @(posedge clk);
    #1;

    // Randomized traffic with random backpressure and input bubbles
    rand_or = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    rand_or = 1'b0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    drain("random_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Random downstream backpressure during the random phase
  always @(posedge clk) begin
    if (rand_or) begin
      #1 out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
